lfc_sequencer: RTL

- Controller that owns the 2-bit count register of the lab counter and sequences its Inc input.
- Next-state is computed by the team's 2-bit increment next-state logic (Inc, Q -> N): hold when Inc=0, binary +1 mod 4 when Inc=1.
- Two increment sources:
  - manual single-step from a raw pushbutton;
  - timed auto-run from a clock divider.
- Sits between board I/O (button/switches) and the count display.

---
 rtl/lfc_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/lfc_sequencer.sv
//==============================================================================
// Module   : lfc_sequencer
// Purpose  : Owns the 2-bit lab-counter register and sequences its Inc input
//            from a synchronized single-step pushbutton or a timed auto-run
//            divider. Optional build macro LFC_STOP_AT_MAX_EN makes auto-run
//            stop (and stay blocked until run drops) when the count hits 11.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lfc_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int DIV_W    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       run,
  input  logic       hold,
  output logic [1:0] q,
  output logic       inc_pulse,
  output logic       wrap,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam logic [DIV_W-1:0] c_TICK_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] c_DIV_ONE   = DIV_W'(1);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_step_edge;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_div_adv;
  logic [1:0]       r_q;
  logic [1:0]       w_q_nxt;
  logic             w_inc;
  logic             w_run_ok;
  logic             w_hit_max;

  // Two-flop synchronizer for the raw button plus an edge-detect flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= step;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_step_edge = r_s2 & ~r_s3;

  // Divider advance with wrap at the last tick of the period.
  assign w_div_adv = (r_div == c_TICK_LAST) ? '0 : (r_div + c_DIV_ONE);

`ifdef LFC_STOP_AT_MAX_EN
  logic r_arm_block;

  // Blocks auto-run restart after a stop-at-max until run is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_arm_block <= 1'b0;
    end else if (w_hit_max) begin
      r_arm_block <= 1'b1;
    end else if (!run) begin
      r_arm_block <= 1'b0;
    end
  end

  assign w_run_ok  = run & ~r_arm_block;
  assign w_hit_max = (r_state == ST_RUN) & w_inc & (r_q == 2'b10);
`else
  assign w_run_ok  = run;
  assign w_hit_max = 1'b0;
`endif

  // FSM state, divider and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_q     <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_q     <= w_q_nxt;
    end
  end

  // Next-state, divider update and increment-source selection.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_inc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Manual steps are only honoured here; the divider sits at zero.
        w_inc     = w_step_edge & ~hold;
        w_div_nxt = '0;
        if (w_run_ok) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_inc = (r_div == c_TICK_LAST) & ~hold & run;
        if (!run) begin
          w_state_nxt = ST_IDLE;
          w_div_nxt   = '0;
        end else if (hold) begin
          // Divider keeps its phase so resume continues the same period.
          w_state_nxt = ST_PAUSE;
        end else if (w_hit_max) begin
          w_state_nxt = ST_IDLE;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = w_div_adv;
        end
      end
      ST_PAUSE: begin
        if (!run) begin
          w_state_nxt = ST_IDLE;
          w_div_nxt   = '0;
        end else if (!hold) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_div_nxt   = '0;
      end
    endcase
  end

  // Team increment next-state logic: hold on Inc=0, +1 mod 4 on Inc=1.
  always_comb begin
    w_q_nxt = r_q;
    if (w_inc) begin
      w_q_nxt = r_q + 2'b01;
    end
  end

  assign q         = r_q;
  assign inc_pulse = w_inc;
  assign wrap      = w_inc & (r_q == 2'b11);
  assign state     = r_state;

endmodule

`default_nettype wire
